// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host transmitter: FSM states,
// frame geometry, parameter defaults and the frame-builder helper.
package ps2_pkg;

    localparam int PS2_FRAME_BITS   = 11;
    localparam int PS2_CLK_HALF_DEF = 2000;
    localparam int PS2_GAP_CYC_DEF  = 4000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HIGH    = 3'd1;
    localparam logic [2:0] ST_LOW     = 3'd2;
    localparam logic [2:0] ST_INHIBIT = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        HIGH    = ST_HIGH,
        LOW     = ST_LOW,
        INHIBIT = ST_INHIBIT,
        GAP     = ST_GAP
    } ps2_state_e;

    // Bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~(^data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the open-collector PS/2 clock line; resets to the
// released (high) level so a reset never looks like a host inhibit.
module ps2_sync (
    input  logic clock_50,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side byte transmitter: generates the 11-bit frame with its own
// clock, backs off on host inhibit and retries the same byte after the line idles.
module ps2_dev_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF = PS2_CLK_HALF_DEF,
    parameter int GAP_CYC  = PS2_GAP_CYC_DEF
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_abort
);

    localparam logic [11:0] HALF_LAST = 12'(CLK_HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                state;
    logic [7:0]                data_q;
    logic [3:0]                bit_idx;
    logic [11:0]               half_cnt;
    logic [15:0]               gap_cnt;
    logic                      clk_sync;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic                      inhibit;

    ps2_sync u_sync (
        .clock_50 (clock_50),
        .reset    (reset),
        .d        (ps2_clk_in),
        .q        (clk_sync)
    );

    // The synchronizer needs a few cycles to see our own release of the clock,
    // so a low line only counts as a host inhibit late in the HIGH half.
    assign frame   = ps2_frame(data_q);
    assign inhibit = (state == HIGH) && !clk_sync && (half_cnt >= 12'd3);

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= 8'd0;
            bit_idx  <= 4'd0;
            half_cnt <= 12'd0;
            gap_cnt  <= 16'd0;
            tx_abort <= 1'b0;
        end else begin
            tx_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        data_q   <= tx_data;
                        bit_idx  <= 4'd0;
                        half_cnt <= 12'd0;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (inhibit) begin
                        tx_abort <= 1'b1;
                        half_cnt <= 12'd0;
                        gap_cnt  <= 16'd0;
                        state    <= INHIBIT;
                    end else if (half_cnt == HALF_LAST) begin
                        half_cnt <= 12'd0;
                        state    <= LOW;
                    end else begin
                        half_cnt <= half_cnt + 12'd1;
                    end
                end
                LOW: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= 12'd0;
                        if (bit_idx == LAST_BIT) begin
                            gap_cnt <= 16'd0;
                            state   <= GAP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            state   <= HIGH;
                        end
                    end else begin
                        half_cnt <= half_cnt + 12'd1;
                    end
                end
                // Any low sample restarts the idle count; the byte is kept for the retry.
                INHIBIT: begin
                    if (!clk_sync) begin
                        gap_cnt <= 16'd0;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= 16'd0;
                        bit_idx  <= 4'd0;
                        half_cnt <= 12'd0;
                        state    <= HIGH;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 16'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_ready   = (state == IDLE);
        busy       = (state != IDLE);
        ps2_clk_oe = (state == LOW);
        ps2_dat_oe = ((state == HIGH) || (state == LOW)) && !frame[bit_idx];
    end

endmodule

// File: doc/ps2_dev_tx.md
PS2_DEV_TX -- requirements
Module: ps2_dev_tx

Interface
REQ-001 Parameter CLK_HALF, default 2000, clock_50 cycles per PS/2 clock half-period (12.5 kHz at 50 MHz); legal range 4..4095.
REQ-002 Parameter GAP_CYC, default 4000, idle clock_50 cycles after each frame before the next byte is accepted; legal range 1..65535.
REQ-003 clock_50  in  1  sole clock, 50 MHz; one clock, all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tx_data  in  8  byte to send (scan code).
REQ-006 tx_valid  in  1  tx_data valid; accepted when tx_valid && tx_ready.
REQ-007 tx_ready  out  1  block able to accept a byte.
REQ-008 ps2_clk_in  in  1  sensed level of the open-collector PS/2 clock line (asynchronous).
REQ-009 ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release.
REQ-010 ps2_dat_oe  out  1  1 = pull PS/2 data low, 0 = release.
REQ-011 busy  out  1  frame in progress, inhibit retry, or gap.
REQ-012 tx_abort  out  1  one-cycle pulse when host inhibit aborts a frame.

Function
REQ-013 Device-to-host PS/2 frame, 11 bits: start 0, data bits 0..7 LSB first, odd parity (XOR-reduce of the data bits, inverted), stop 1.
REQ-014 FSM states: IDLE, HIGH, LOW, INHIBIT, GAP.
REQ-015 IDLE: tx_ready=1, both oe=0, busy=0; on accept, latch tx_data, bit index=0, go to HIGH; tx_ready falls the cycle after accept.
REQ-016 HIGH: ps2_clk_oe=0; ps2_dat_oe=~frame[bit] from the first HIGH cycle; lasts CLK_HALF cycles, then LOW.
REQ-017 LOW: ps2_clk_oe=1, data unchanged; lasts CLK_HALF cycles; then bit index+1 to HIGH, or, after bit 10, to GAP with both oe=0.
REQ-018 Frame length: exactly 22*CLK_HALF cycles from the first HIGH cycle to GAP entry.
REQ-019 ps2_clk_in passes through a 2-flop synchronizer; inhibit means the synchronized clock is 0 in HIGH with the half-period counter >= 3.
REQ-020 On inhibit: both oe=0 next cycle, tx_abort=1 for one cycle, go to INHIBIT; the latched byte is retained.
REQ-021 INHIBIT: wait until the synchronized clock has been 1 for GAP_CYC consecutive cycles, then restart the same byte at bit 0 in HIGH; no new byte is accepted.
REQ-022 Inhibit during LOW is undetectable and ignored.
REQ-023 GAP: both oe=0, busy=1, counts GAP_CYC cycles, then IDLE.
REQ-024 tx_valid while tx_ready=0 is ignored; the byte is not queued.
REQ-025 Counters are wide enough for the parameter maxima and never wrap within a phase.

Reset
REQ-026 With reset=1 at a clock edge, the next state is: IDLE, tx_ready=1, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, tx_abort=0, counters and bit index 0, synchronizer flops 1.
REQ-027 Reset mid-frame discards the byte and releases both lines on the next cycle; no tx_abort pulse.

Structure
REQ-028 Shared package ps2_pkg holds the FSM state enum, PS2_FRAME_BITS=11, and the CLK_HALF/GAP_CYC defaults.
REQ-029 Sub-module ps2_sync (2-flop synchronizer, reset value 1) conditions ps2_clk_in; everything else is in ps2_dev_tx.

Verification
Bench uses CLK_HALF=4, GAP_CYC=10, lines modelled as pull-ups wired-AND with oe, and a host sampling data on each clock falling edge.
REQ-030 Send 0x1C -> host decodes bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0); 88 cycles of HIGH/LOW; busy clears 10 cycles later.
REQ-031 Send 0xF0, then 0x00 held valid -> parity 1 for both; 0x00 accepted only after the GAP of the first frame; tx_ready never high mid-frame.
REQ-032 Host pulls clock low for 20 cycles during bit 4 HIGH -> one tx_abort pulse, lines released, full 0x1C frame resent 10 cycles after release.
REQ-033 reset asserted at bit 6 -> next cycle both oe=0, tx_ready=1; a new byte 0x5A is then sent correctly.
REQ-034 tx_valid pulsed during a frame -> no extra frame, byte dropped, busy behaviour unchanged.
